// File: rtl/product_acc_pkg.sv
// Shared constants, FSM state type and width helper for the product accumulator.
package product_acc_pkg;

   localparam int DATA_W_DEF  = 256;
   localparam int SPLIT_W_DEF = 128;
   localparam int GUARD_W_DEF = 8;
   localparam int ACC_LEN_DEF = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } acc_state_t;

   // Bits needed to hold a beat count in the range 0..n.
   function automatic int cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/product_acc_256b_stage.sv
// One registered half of the split accumulator: acc <= (restart ? 0 : acc) + add + cin.
// The unregistered next value and carry are exposed so the parent can register
// them elsewhere (stage-1 carry, output capture, overflow tracking).
module acc_split_stage #(
   parameter int W = 128
) (
   input  logic         iClk,
   input  logic         iRst,
   input  logic         iEn,
   input  logic         iClr,
   input  logic         iUpd,
   input  logic         iRestart,
   input  logic [W-1:0] iAdd,
   input  logic         iCin,
   output logic [W-1:0] oAcc,
   output logic [W-1:0] oNext,
   output logic         oCout
);

   logic [W:0] sum;

   assign sum   = {1'b0, (iRestart ? {W{1'b0}} : oAcc)} + {1'b0, iAdd} + {{W{1'b0}}, iCin};
   assign oNext = sum[W-1:0];
   assign oCout = sum[W];

   // Accumulator register: cleared by reset/clear, updates only when enabled and selected.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst)             oAcc <= '0;
      else if (iClr)        oAcc <= '0;
      else if (iEn && iUpd) oAcc <= oNext;
   end

endmodule

// File: rtl/product_acc_256b.sv
// Group accumulator for 256-bit products with a two-stage split carry chain.
// Optional macro PRODUCT_ACC_OVF_EN adds oOvf, a per-group sticky wrap flag.
module product_acc_256b
   import product_acc_pkg::*;
#(
   parameter  int DATA_W  = DATA_W_DEF,
   parameter  int SPLIT_W = SPLIT_W_DEF,
   parameter  int GUARD_W = GUARD_W_DEF,
   parameter  int ACC_LEN = ACC_LEN_DEF,
   localparam int ACC_W   = DATA_W + GUARD_W,
   localparam int HI_W    = ACC_W - SPLIT_W,
   localparam int CNT_W   = cnt_w(ACC_LEN)
) (
   input  logic              iClk,
   input  logic              iRst,
   input  logic              iEn,
   input  logic              iClr,
   input  logic              iValid,
   input  logic              iLast,
   input  logic [DATA_W-1:0] iData,
   output logic [ACC_W-1:0]  oData,
   output logic              oValid,
   output logic [CNT_W-1:0]  oCount,
   output logic              oBusy
`ifdef PRODUCT_ACC_OVF_EN
   ,
   output logic              oOvf
`endif
);

   acc_state_t       state;
   logic [CNT_W-1:0] cnt, cnt_nxt, close_cnt_r;
   logic             accept, first, close;
   logic             close_r, restart_r, carry_r;
   logic [HI_W-1:0]  hi_data_r;
   logic [SPLIT_W-1:0] acc_lo, lo_sum_unused;
   logic             lo_cout;
   logic [HI_W-1:0]  acc_hi_unused, hi_nxt;
   logic             hi_cout;

   assign accept  = iEn & iValid;
   assign first   = (state == IDLE);
   assign cnt_nxt = first ? CNT_W'(1) : cnt + CNT_W'(1);
   assign close   = accept & (iLast | (cnt_nxt == CNT_W'(ACC_LEN)));
   assign oBusy   = (state == ACCUM) | close_r;

   // Low half adds the product directly at the acceptance edge.
   acc_split_stage #(.W(SPLIT_W)) u_lo (
      .iClk(iClk), .iRst(iRst), .iEn(iEn), .iClr(iClr),
      .iUpd(accept), .iRestart(first), .iAdd(iData[SPLIT_W-1:0]), .iCin(1'b0),
      .oAcc(acc_lo), .oNext(lo_sum_unused), .oCout(lo_cout)
   );

   // High half runs one enabled cycle behind; idle cycles add zero and hold.
   acc_split_stage #(.W(HI_W)) u_hi (
      .iClk(iClk), .iRst(iRst), .iEn(iEn), .iClr(iClr),
      .iUpd(1'b1), .iRestart(restart_r), .iAdd(hi_data_r), .iCin(carry_r),
      .oAcc(acc_hi_unused), .oNext(hi_nxt), .oCout(hi_cout)
   );

   // Group control: FSM, beat count and the stage-1 pipeline registers.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst || iClr) begin
         state       <= IDLE;
         cnt         <= '0;
         close_cnt_r <= '0;
         close_r     <= 1'b0;
         restart_r   <= 1'b0;
         carry_r     <= 1'b0;
         hi_data_r   <= '0;
      end else if (iEn) begin
         restart_r <= accept & first;
         carry_r   <= accept & lo_cout;
         hi_data_r <= accept ? HI_W'(iData[DATA_W-1:SPLIT_W]) : '0;
         close_r   <= close;
         if (close) close_cnt_r <= cnt_nxt;
         if (accept) begin
            state <= close ? IDLE : ACCUM;
            cnt   <= close ? '0 : cnt_nxt;
         end
      end
   end

`ifdef PRODUCT_ACC_OVF_EN
   logic ovf_r, ovf_nxt;
   assign ovf_nxt = (restart_r ? 1'b0 : ovf_r) | hi_cout;

   // Sticky wrap flag for the group currently in the high stage.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst || iClr) ovf_r <= 1'b0;
      else if (iEn)     ovf_r <= ovf_nxt;
   end
`else
   logic ovf_unused;
   assign ovf_unused = hi_cout;
`endif

   // Result capture one enabled edge after the closing beat; oValid pulses for one enabled cycle.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst || iClr) begin
         oData  <= '0;
         oValid <= 1'b0;
         oCount <= '0;
`ifdef PRODUCT_ACC_OVF_EN
         oOvf   <= 1'b0;
`endif
      end else if (iEn) begin
         oValid <= close_r;
         if (close_r) begin
            oData  <= {hi_nxt, acc_lo};
            oCount <= close_cnt_r;
`ifdef PRODUCT_ACC_OVF_EN
            oOvf   <= ovf_nxt;
`endif
         end
      end
   end

endmodule

// File: tb/tb_product_acc_256b.sv
// Scoreboard bench for product_acc_256b (ACC_LEN=4, GUARD_W=1 so wrap is easy to reach).
module tb_product_acc_256b;

   localparam int ACC_LEN = 4;
   localparam int ACC_W   = 257;

   logic             iClk = 1'b0;
   logic             iRst = 1'b1;
   logic             iEn = 1'b0, iClr = 1'b0, iValid = 1'b0, iLast = 1'b0;
   logic [255:0]     iData = '0;
   logic [ACC_W-1:0] oData;
   logic             oValid, oBusy;
   logic [2:0]       oCount;
`ifdef PRODUCT_ACC_OVF_EN
   logic             oOvf;
`endif

   product_acc_256b #(.DATA_W(256), .SPLIT_W(128), .GUARD_W(1), .ACC_LEN(ACC_LEN)) dut (
      .iClk(iClk), .iRst(iRst), .iEn(iEn), .iClr(iClr), .iValid(iValid), .iLast(iLast),
      .iData(iData), .oData(oData), .oValid(oValid), .oCount(oCount), .oBusy(oBusy)
`ifdef PRODUCT_ACC_OVF_EN
      , .oOvf(oOvf)
`endif
   );

   always #5 iClk = ~iClk;

   typedef struct {
      logic [ACC_W-1:0] data;
      logic [2:0]       cnt;
      logic             ovf;
      int               at;
   } exp_t;

   exp_t             q[$];
   int               checks = 0, errors = 0;
   int               edge_n = 0;
   bit               last_edge_en = 1'b0;
   logic [ACC_W-1:0] last_data = '0;

   // reference model state: running group sum, beat count, wrap flag
   logic [ACC_W-1:0] g_sum = '0;
   int               g_cnt = 0;
   logic             g_ovf = 1'b0;

   task automatic chk(input string name, input logic [ACC_W-1:0] got, input logic [ACC_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic model_beat(input logic l, input logic [255:0] d);
      logic [ACC_W:0] s;
      if (g_cnt == 0) begin g_sum = '0; g_ovf = 1'b0; end
      s     = {1'b0, g_sum} + {2'b0, d};
      g_ovf = g_ovf | s[ACC_W];
      g_sum = s[ACC_W-1:0];
      g_cnt++;
      if (l || g_cnt == ACC_LEN) begin
         q.push_back('{g_sum, 3'(g_cnt), g_ovf, edge_n + 1});
         g_cnt = 0;
      end
   endtask

   task automatic model_clear();
      g_cnt = 0;
      q.delete();
   endtask

   task automatic step(input logic en, input logic v, input logic l, input logic [255:0] d);
      iEn = en; iValid = v; iLast = l; iData = d;
      @(posedge iClk);
      if (en) begin
         edge_n++;
         if (v) model_beat(l, d);
      end
      last_edge_en = en;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0);
   endtask

   task automatic clr_step(input logic en);
      iClr = 1'b1; iEn = en; iValid = 1'b1; iLast = 1'b1; iData = 256'd99;
      @(posedge iClk);
      model_clear();
      last_edge_en = 1'b0;
      #1;
      iClr = 1'b0;
   endtask

   task automatic chk_zero_outs(input string tag);
      chk({tag, "_odata"},  oData, '0);
      chk({tag, "_ovalid"}, ACC_W'(oValid), '0);
      chk({tag, "_ocount"}, ACC_W'(oCount), '0);
      chk({tag, "_obusy"},  ACC_W'(oBusy), '0);
   endtask

   function automatic logic [255:0] rnd256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Monitor: pops the scoreboard on each fresh oValid, checks hold during stalls and missing results.
   always @(negedge iClk) begin
      exp_t e;
      if (!iRst) begin
         if (oValid && last_edge_en) begin
            if (q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_ovalid got data=%0h exp=none", oData);
            end else begin
               e = q.pop_front();
               chk("odata",   oData, e.data);
               chk("ocount",  ACC_W'(oCount), ACC_W'(e.cnt));
               chk("latency", ACC_W'(edge_n), ACC_W'(e.at));
`ifdef PRODUCT_ACC_OVF_EN
               chk("oovf",    ACC_W'(oOvf), ACC_W'(e.ovf));
`endif
               last_data = oData;
            end
         end else if (oValid) begin
            chk("held_odata", oData, last_data);
         end else if (last_edge_en && q.size() > 0 && q[0].at <= edge_n) begin
            checks++; errors++;
            $display("FAIL missing_ovalid got=none exp data=%0h", q[0].data);
            void'(q.pop_front());
         end
      end
   end

   initial begin
      logic [255:0] ones, m128;
      ones = '1;
      m128 = {128'd0, {128{1'b1}}};

      #3 chk_zero_outs("por");
      #9 iRst = 1'b0;

      // reset mid-group, then a length-limited group
      step(1, 1, 0, 256'd1);
      chk("busy_open", ACC_W'(oBusy), ACC_W'(1));
      step(1, 1, 0, 256'd2);
      step(1, 1, 0, 256'd3);
      #2 iRst = 1'b1;
      #1 chk_zero_outs("midrst");
      model_clear();
      last_edge_en = 1'b0;
      #4 iRst = 1'b0;
      step(1, 1, 0, 256'd1); step(1, 1, 0, 256'd2);
      step(1, 1, 0, 256'd3); step(1, 1, 0, 256'd4);
      idle(3);
      chk("busy_idle", ACC_W'(oBusy), '0);

      // carry across the split boundary
      step(1, 1, 0, m128); step(1, 1, 1, 256'd1);
      idle(3);

      // back-to-back single-beat groups
      step(1, 1, 1, 256'd5); step(1, 1, 1, 256'd7);
      idle(3);

      // stall inside a group and while the result is presented
      step(1, 1, 0, 256'd1); step(1, 1, 0, 256'd2);
      for (int i = 0; i < 3; i++) step(0, 1, 1, rnd256());
      step(1, 1, 1, 256'd3);
      step(1, 0, 0, '0);
      step(0, 0, 0, '0); step(0, 0, 0, '0);
      idle(2);

      // guard wrap, then a clean group
      step(1, 1, 0, ones); step(1, 1, 0, ones); step(1, 1, 1, ones);
      step(1, 1, 1, 256'd1);
      idle(3);

      // clear discards an in-flight result and an open group
      step(1, 1, 0, 256'd9); step(1, 1, 1, 256'd10);
      clr_step(1'b0);
      idle(3);
      step(1, 1, 0, 256'd4);
      clr_step(1'b1);
      step(1, 1, 1, 256'd6);
      idle(3);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 79) == 0) clr_step(1'($urandom_range(0, 1)));
         else step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) != 0),
                   1'($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 3) == 0) ? ones : rnd256());
      end
      idle(4);
      chk("drain_queue", ACC_W'(q.size()), '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
